// File: rtl/mc14500b_seq.sv
// MC14500B-style 1-instruction-per-clock industrial control unit with a
// call/return stack, skip flag, gated I/O and registered strobes.
module mc14500b_seq #(
    parameter int WIDTH       = 1,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              x2,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] pc,
    input  logic [3:0]        instr,
    input  logic [ADDR_W-1:0] operand,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic [WIDTH-1:0]  rr,
    output logic              write,
    output logic              jmp,
    output logic              rtn,
    output logic              flg0,
    output logic              flgf,
    output logic              stk_err
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [3:0] {
        OP_NOP0, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
        OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
    } op_t;

    op_t               op;
    logic              ien, oen, skip;
    logic [SP_W-1:0]   sp, sp_m1;
    logic [ADDR_W-1:0] stack [2**IDX_W];
    logic [ADDR_W-1:0] pc_inc;
    logic [WIDTH-1:0]  d;

    logic [ADDR_W-1:0] pc_n;
    logic [WIDTH-1:0]  rr_n, dout_n;
    logic [SP_W-1:0]   sp_n;
    logic              ien_n, oen_n, skip_n, err_n, push;
    logic              write_n, jmp_n, rtn_n, flg0_n, flgf_n;

    assign op     = op_t'(instr);
    assign pc_inc = pc + 1'b1;
    assign sp_m1  = sp - 1'b1;
    assign d      = ien ? data_in : '0;

    always_comb begin
        pc_n    = pc;
        rr_n    = rr;
        dout_n  = data_out;
        ien_n   = ien;
        oen_n   = oen;
        skip_n  = skip;
        sp_n    = sp;
        err_n   = stk_err;
        push    = 1'b0;
        write_n = 1'b0;
        jmp_n   = 1'b0;
        rtn_n   = 1'b0;
        flg0_n  = 1'b0;
        flgf_n  = 1'b0;
        if (run) begin
            pc_n = pc_inc;
            if (skip) begin
                skip_n = 1'b0;
            end else begin
                case (op)
                    OP_NOP0: flg0_n = 1'b1;
                    OP_LD:   rr_n = d;
                    OP_LDC:  rr_n = ~d;
                    OP_AND:  rr_n = rr & d;
                    OP_ANDC: rr_n = rr & ~d;
                    OP_OR:   rr_n = rr | d;
                    OP_ORC:  rr_n = rr | ~d;
                    OP_XNOR: rr_n = ~(rr ^ d);
                    OP_STO: if (oen) begin
                        dout_n  = rr;
                        write_n = 1'b1;
                    end
                    OP_STOC: if (oen) begin
                        dout_n  = ~rr;
                        write_n = 1'b1;
                    end
                    OP_IEN:  ien_n = data_in[0];
                    OP_OEN:  oen_n = data_in[0];
                    OP_JMP: begin
                        // A full stack drops the return address but the jump still happens
                        pc_n  = operand;
                        jmp_n = 1'b1;
                        if (sp == SP_FULL) begin
                            err_n = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + 1'b1;
                        end
                    end
                    OP_RTN: begin
                        rtn_n = 1'b1;
                        if (sp == '0) begin
                            err_n = 1'b1;
                        end else begin
                            pc_n   = stack[sp_m1[IDX_W-1:0]];
                            sp_n   = sp_m1;
                            skip_n = 1'b1;
                        end
                    end
                    OP_SKZ:  if (!rr[0]) skip_n = 1'b1;
                    OP_NOPF: flgf_n = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge x2) begin
        if (!rst_n) begin
            pc       <= '0;
            rr       <= '0;
            data_out <= '0;
            ien      <= 1'b0;
            oen      <= 1'b0;
            skip     <= 1'b0;
            sp       <= '0;
            stk_err  <= 1'b0;
            write    <= 1'b0;
            jmp      <= 1'b0;
            rtn      <= 1'b0;
            flg0     <= 1'b0;
            flgf     <= 1'b0;
        end else begin
            pc       <= pc_n;
            rr       <= rr_n;
            data_out <= dout_n;
            ien      <= ien_n;
            oen      <= oen_n;
            skip     <= skip_n;
            sp       <= sp_n;
            stk_err  <= err_n;
            write    <= write_n;
            jmp      <= jmp_n;
            rtn      <= rtn_n;
            flg0     <= flg0_n;
            flgf     <= flgf_n;
        end
    end

    // Stack storage needs no reset; the pointer alone defines validity.
    always_ff @(posedge x2) begin
        if (rst_n && push) stack[sp[IDX_W-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_mc14500b_seq.sv
// Bench for mc14500b_seq: directed scenarios plus randomized programs checked
// against a queue-based behavioural model.
module tb_mc14500b_seq;
    localparam int W = 4, AW = 8, SD = 2;

    logic          x2 = 1'b0;
    logic          rst_n, run;
    logic [AW-1:0] pc, operand;
    logic [3:0]    instr;
    logic [W-1:0]  data_in, data_out, rr;
    logic          write, jmp, rtn, flg0, flgf, stk_err;

    logic [3:0]    p_op  [256];
    logic [7:0]    p_arg [256];
    logic [W-1:0]  p_din [256];

    int errors = 0, checks = 0;

    // behavioural model state
    logic [7:0]   m_pc;
    logic [W-1:0] m_rr, m_dout;
    logic         m_ien, m_oen, m_skip, m_err;
    logic         m_write, m_jmp, m_rtn, m_f0, m_ff;
    logic [7:0]   m_stk[$];

    mc14500b_seq #(.WIDTH(W), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .x2(x2), .rst_n(rst_n), .run(run), .pc(pc), .instr(instr),
        .operand(operand), .data_in(data_in), .data_out(data_out), .rr(rr),
        .write(write), .jmp(jmp), .rtn(rtn), .flg0(flg0), .flgf(flgf),
        .stk_err(stk_err)
    );

    always #5 x2 = ~x2;

    assign instr   = p_op[pc];
    assign operand = p_arg[pc];
    assign data_in = p_din[pc];

    function automatic logic [21:0] dut_out();
        return {pc, rr, data_out, write, jmp, rtn, flg0, flgf, stk_err};
    endfunction

    function automatic logic [21:0] model_out();
        return {m_pc, m_rr, m_dout, m_write, m_jmp, m_rtn, m_f0, m_ff, m_err};
    endfunction

    task automatic model_step();
        logic [3:0]   op;
        logic [W-1:0] din, dd;
        op  = p_op[m_pc];
        din = p_din[m_pc];
        dd  = m_ien ? din : '0;
        {m_write, m_jmp, m_rtn, m_f0, m_ff} = '0;
        if (!rst_n) begin
            m_pc = 0; m_rr = 0; m_dout = 0; m_ien = 0; m_oen = 0;
            m_skip = 0; m_err = 0;
            m_stk.delete();
        end else if (run) begin
            if (m_skip) begin
                m_skip = 0;
                m_pc = m_pc + 1;
            end else begin
                case (op)
                    0:  begin m_f0 = 1; m_pc = m_pc + 1; end
                    1:  begin m_rr = dd; m_pc = m_pc + 1; end
                    2:  begin m_rr = ~dd; m_pc = m_pc + 1; end
                    3:  begin m_rr = m_rr & dd; m_pc = m_pc + 1; end
                    4:  begin m_rr = m_rr & ~dd; m_pc = m_pc + 1; end
                    5:  begin m_rr = m_rr | dd; m_pc = m_pc + 1; end
                    6:  begin m_rr = m_rr | ~dd; m_pc = m_pc + 1; end
                    7:  begin m_rr = ~(m_rr ^ dd); m_pc = m_pc + 1; end
                    8:  begin if (m_oen) begin m_dout = m_rr; m_write = 1; end m_pc = m_pc + 1; end
                    9:  begin if (m_oen) begin m_dout = ~m_rr; m_write = 1; end m_pc = m_pc + 1; end
                    10: begin m_ien = din[0]; m_pc = m_pc + 1; end
                    11: begin m_oen = din[0]; m_pc = m_pc + 1; end
                    12: begin
                        if (m_stk.size() < SD) m_stk.push_back(m_pc + 8'd1);
                        else m_err = 1;
                        m_pc = p_arg[m_pc];
                        m_jmp = 1;
                    end
                    13: begin
                        m_rtn = 1;
                        if (m_stk.size() > 0) begin
                            m_pc = m_stk.pop_back();
                            m_skip = 1;
                        end else begin
                            m_err = 1;
                            m_pc = m_pc + 1;
                        end
                    end
                    14: begin if (!m_rr[0]) m_skip = 1; m_pc = m_pc + 1; end
                    default: begin m_ff = 1; m_pc = m_pc + 1; end
                endcase
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge x2);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            p_op[i] = 4'h0; p_arg[i] = 8'h0; p_din[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_prog();
        rst_n = 1'b0; run = 1'b0;
        step();
        checks++;
        if (dut_out() !== 22'h0) begin
            errors++; $display("FAIL reset_state: got %h want 0", dut_out());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_gating();
        clear_prog();
        p_op[0] = 4'h6; p_din[0] = 4'h0;
        p_op[1] = 4'hA; p_din[1] = 4'h1;
        p_op[2] = 4'hB; p_din[2] = 4'h1;
        p_op[3] = 4'h1; p_din[3] = 4'hA;
        p_op[4] = 4'h8;
        do_reset();
        step();
        checks++;
        if (rr !== 4'hF) begin errors++; $display("FAIL gating_orc: rr=%h want f", rr); end
        step(); step(); step();
        checks++;
        if (rr !== 4'hA) begin errors++; $display("FAIL gating_ld: rr=%h want a", rr); end
        step();
        checks++;
        if (data_out !== 4'hA || write !== 1'b1) begin
            errors++; $display("FAIL gating_sto: dout=%h write=%b want a 1", data_out, write);
        end
        step();
        checks++;
        if (write !== 1'b0) begin errors++; $display("FAIL gating_write_once: write=%b want 0", write); end
        checks++;
        if (dut_out() !== model_out()) begin
            errors++; $display("FAIL gating_model: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_disabled_io();
        int nw = 0;
        clear_prog();
        p_op[0] = 4'h1; p_din[0] = 4'h5;
        p_op[1] = 4'h9;
        do_reset();
        step();
        checks++;
        if (rr !== 4'h0) begin errors++; $display("FAIL noio_ld: rr=%h want 0", rr); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (write) nw++;
        end
        checks++;
        if (data_out !== 4'h0 || nw != 0) begin
            errors++; $display("FAIL noio_stoc: dout=%h writes=%0d want 0 0", data_out, nw);
        end
    endtask

    task automatic test_call_return();
        int nj = 0, nr = 0, nf = 0;
        logic [7:0] seq [4];
        clear_prog();
        p_op[3] = 4'hC; p_arg[3] = 8'h20;
        p_op[8'h20] = 4'hD;
        p_op[4] = 4'hF;
        do_reset();
        step(); step(); step();
        seq[0] = pc;
        for (int i = 1; i < 4; i++) begin
            step();
            seq[i] = pc;
            nj += int'(jmp); nr += int'(rtn); nf += int'(flgf);
        end
        checks++;
        if ({seq[0], seq[1], seq[2], seq[3]} !== 32'h03200405) begin
            errors++;
            $display("FAIL call_pc_seq: got %h %h %h %h want 03 20 04 05", seq[0], seq[1], seq[2], seq[3]);
        end
        checks++;
        if (nj != 1 || nr != 1 || nf != 0) begin
            errors++; $display("FAIL call_strobes: jmp=%0d rtn=%0d flgf=%0d want 1 1 0", nj, nr, nf);
        end
        checks++;
        if (stk_err !== 1'b0) begin errors++; $display("FAIL call_no_err: stk_err=%b want 0", stk_err); end
    endtask

    task automatic test_stack_limits();
        clear_prog();
        p_op[0] = 4'hC; p_arg[0] = 8'h10;
        p_op[8'h10] = 4'hC; p_arg[8'h10] = 8'h20;
        p_op[8'h20] = 4'hC; p_arg[8'h20] = 8'h30;
        p_op[8'h30] = 4'hD;
        p_op[8'h12] = 4'hD;
        p_op[2] = 4'hD;
        p_op[3] = 4'hD;
        p_op[4] = 4'hF;
        do_reset();
        step(); step();
        checks++;
        if (stk_err !== 1'b0) begin errors++; $display("FAIL stack_err_early: stk_err=%b want 0", stk_err); end
        step();
        checks++;
        if (pc !== 8'h30 || stk_err !== 1'b1) begin
            errors++; $display("FAIL stack_overflow: pc=%h err=%b want 30 1", pc, stk_err);
        end
        step();
        checks++;
        if (pc !== 8'h11) begin errors++; $display("FAIL stack_pop1: pc=%h want 11", pc); end
        step(); step(); step(); step();
        checks++;
        if (pc !== 8'h3) begin errors++; $display("FAIL stack_underflow: pc=%h want 3", pc); end
        step();
        checks++;
        if (pc !== 8'h4 || rtn !== 1'b1) begin
            errors++; $display("FAIL stack_rtn_empty: pc=%h rtn=%b want 4 1", pc, rtn);
        end
        step();
        checks++;
        if (flgf !== 1'b1 || stk_err !== 1'b1) begin
            errors++; $display("FAIL stack_no_skip: flgf=%b err=%b want 1 1", flgf, stk_err);
        end
    endtask

    task automatic test_skz();
        clear_prog();
        p_op[0] = 4'hA; p_din[0] = 4'h1;
        p_op[1] = 4'h1; p_din[1] = 4'h0;
        p_op[2] = 4'hE;
        p_op[3] = 4'hF;
        p_op[4] = 4'h1; p_din[4] = 4'h1;
        p_op[5] = 4'hE;
        p_op[6] = 4'hF;
        do_reset();
        step(); step(); step();
        step();
        checks++;
        if (flgf !== 1'b0 || pc !== 8'h4) begin
            errors++; $display("FAIL skz_skipped: flgf=%b pc=%h want 0 4", flgf, pc);
        end
        step(); step(); step();
        checks++;
        if (flgf !== 1'b1) begin errors++; $display("FAIL skz_taken: flgf=%b want 1", flgf); end
        step();
        checks++;
        if (flgf !== 1'b0) begin errors++; $display("FAIL skz_pulse: flgf=%b want 0", flgf); end
    endtask

    task automatic test_stall_reset();
        clear_prog();
        p_op[0] = 4'hA; p_din[0] = 4'h1;
        p_op[1] = 4'h1; p_din[1] = 4'h2;
        p_op[2] = 4'hE;
        p_op[3] = 4'hF;
        do_reset();
        step(); step();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 8'h2 || rr !== 4'h2 || {write, jmp, rtn, flg0, flgf} !== 5'b0) begin
                errors++; $display("FAIL stall_hold: pc=%h rr=%h want 2 2", pc, rr);
            end
        end
        run = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (dut_out() !== 22'h0) begin errors++; $display("FAIL reset_mid: got %h want 0", dut_out()); end
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (pc !== 8'h2 || rr !== 4'h2) begin
            errors++; $display("FAIL reset_restart: pc=%h rr=%h want 2 2", pc, rr);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) begin
                p_op[i]  = 4'($urandom_range(0, 15));
                p_arg[i] = 8'($urandom_range(0, 255));
                p_din[i] = W'($urandom_range(0, 15));
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                run   = ($urandom_range(0, 9) != 0);
                rst_n = ($urandom_range(0, 99) != 0);
                step();
                checks++;
                if (dut_out() !== model_out()) begin
                    errors++;
                    $display("FAIL random_t%0d_c%0d: got %h want %h", t, c, dut_out(), model_out());
                end
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0;
        test_reset();
        test_gating();
        test_disabled_io();
        test_call_return();
        test_stack_limits();
        test_skz();
        test_stall_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
